// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with programmable almost-full/almost-empty,
// selectable registered or first-word-fall-through read, and sticky error flags.
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 64,
    parameter int AF_THRESH = DEPTH - 4,
    parameter int AE_THRESH = 4,
    parameter bit FWFT      = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_wr_en,
    input  logic [DATA_W-1:0]            i_wr_data,
    input  logic                         i_rd_en,
    input  logic                         i_clr_err,
    output logic [DATA_W-1:0]            o_rd_data,
    output logic                         o_rd_valid,
    output logic                         o_full,
    output logic                         o_empty,
    output logic                         o_almost_full,
    output logic                         o_almost_empty,
    output logic [$clog2(DEPTH):0]       o_count,
    output logic                         o_overflow,
    output logic                         o_underflow
);
    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0]   AF_T    = (AW+1)'(AF_THRESH);
    localparam logic [AW:0]   AE_T    = (AW+1)'(AE_THRESH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              r_overflow;
    logic              r_underflow;

    logic w_full;
    logic w_empty;
    logic w_wa;
    logic w_ra;

    assign w_full  = (r_count == CNT_MAX);
    assign w_empty = (r_count == '0);
    assign w_wa    = i_wr_en & ~w_full;
    assign w_ra    = i_rd_en & ~w_empty;

    // Storage is deliberately left out of reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (w_wa) r_mem[r_wr_ptr] <= i_wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wa) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_ra) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wa, w_ra})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            // A set event in the same cycle as clr_err keeps the flag high.
            r_overflow  <= (i_wr_en & w_full)  | (r_overflow  & ~i_clr_err);
            r_underflow <= (i_rd_en & w_empty) | (r_underflow & ~i_clr_err);
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign o_rd_data  = r_mem[r_rd_ptr];
            assign o_rd_valid = ~w_empty;
        end else begin : g_reg
            logic [DATA_W-1:0] r_rd_data;
            logic              r_rd_valid;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_rd_data  <= '0;
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_ra;
                    if (w_ra) r_rd_data <= r_mem[r_rd_ptr];
                end
            end
            assign o_rd_data  = r_rd_data;
            assign o_rd_valid = r_rd_valid;
        end
    endgenerate

    assign o_full         = w_full;
    assign o_empty        = w_empty;
    assign o_almost_full  = (r_count >= AF_T);
    assign o_almost_empty = (r_count <= AE_T);
    assign o_count        = r_count;
    assign o_overflow     = r_overflow;
    assign o_underflow    = r_underflow;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench: one registered-read FIFO and one FWFT FIFO, both 8x8 with
// almost-full at 6 and almost-empty at 2.
module tb_sync_fifo_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    // registered-read instance
    logic       a_wr_en = 0, a_rd_en = 0, a_clr = 0;
    logic [7:0] a_wr_data = 0, a_rd_data;
    logic       a_rd_valid, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
    logic [3:0] a_count;

    // FWFT instance
    logic       b_wr_en = 0, b_rd_en = 0, b_clr = 0;
    logic [7:0] b_wr_data = 0, b_rd_data;
    logic       b_rd_valid, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
    logic [3:0] b_count;

    sync_fifo_param #(.DATA_W(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1'b0)) u_a (
        .clk(clk), .rst(rst), .i_wr_en(a_wr_en), .i_wr_data(a_wr_data), .i_rd_en(a_rd_en),
        .i_clr_err(a_clr), .o_rd_data(a_rd_data), .o_rd_valid(a_rd_valid), .o_full(a_full),
        .o_empty(a_empty), .o_almost_full(a_af), .o_almost_empty(a_ae), .o_count(a_count),
        .o_overflow(a_ovf), .o_underflow(a_unf));

    sync_fifo_param #(.DATA_W(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1'b1)) u_b (
        .clk(clk), .rst(rst), .i_wr_en(b_wr_en), .i_wr_data(b_wr_data), .i_rd_en(b_rd_en),
        .i_clr_err(b_clr), .o_rd_data(b_rd_data), .o_rd_valid(b_rd_valid), .o_full(b_full),
        .o_empty(b_empty), .o_almost_full(b_af), .o_almost_empty(b_ae), .o_count(b_count),
        .o_overflow(b_ovf), .o_underflow(b_unf));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // status vector {full, empty, almost_full, almost_empty}
    function automatic logic [3:0] a_st();
        return {a_full, a_empty, a_af, a_ae};
    endfunction

    initial begin
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_count", a_count, 0);
        chk("rst_status", a_st(), 4'b0101);
        chk("rst_rd_valid", a_rd_valid, 0);
        chk("rst_rd_data", a_rd_data, 0);
        chk("rst_errs", {a_ovf, a_unf}, 0);

        // fill 1..8
        for (int i = 1; i <= 8; i++) begin
            a_wr_en = 1; a_wr_data = 8'(i);
            step();
            chk("fill_count", a_count, i);
            chk("fill_af", a_af, (i >= 6));
            chk("fill_ae", a_ae, (i <= 2));
        end
        a_wr_en = 0;
        chk("fill_full", a_full, 1);

        // 9th write is discarded
        a_wr_en = 1; a_wr_data = 8'hEE;
        step();
        a_wr_en = 0;
        chk("ovf_count", a_count, 8);
        chk("ovf_flag", a_ovf, 1);

        for (int i = 1; i <= 8; i++) begin
            a_rd_en = 1;
            step();
            chk("drain_valid", a_rd_valid, 1);
            chk("drain_data", a_rd_data, i);
        end
        a_rd_en = 0;
        step();
        chk("drain_valid_off", a_rd_valid, 0);
        chk("drain_hold", a_rd_data, 8'h08);
        chk("drain_status", a_st(), 4'b0101);

        a_rd_en = 1;
        step();
        a_rd_en = 0;
        chk("unf_flag", a_unf, 1);
        chk("unf_valid", a_rd_valid, 0);
        chk("unf_count", a_count, 0);

        a_clr = 1;
        step();
        a_clr = 0;
        chk("clr_flags", {a_ovf, a_unf}, 0);

        for (int i = 1; i <= 8; i++) begin
            a_wr_en = 1; a_wr_data = 8'(8'h10 + i);
            step();
        end
        a_clr = 1;
        step();
        a_wr_en = 0; a_clr = 0;
        chk("clr_vs_set_ovf", a_ovf, 1);
        chk("clr_vs_set_count", a_count, 8);
        a_clr = 1;
        step();
        a_clr = 0;
        chk("clr_again", a_ovf, 0);

        // simultaneous while full: read wins, write dropped
        a_wr_en = 1; a_rd_en = 1; a_wr_data = 8'h77;
        step();
        a_wr_en = 0; a_rd_en = 0;
        chk("simfull_count", a_count, 7);
        chk("simfull_ovf", a_ovf, 1);
        chk("simfull_data", a_rd_data, 8'h11);
        chk("simfull_valid", a_rd_valid, 1);
        for (int i = 2; i <= 8; i++) begin
            a_rd_en = 1;
            step();
            chk("simfull_drain", a_rd_data, 8'(8'h10 + i));
        end
        a_rd_en = 0; a_clr = 1;
        step();
        a_clr = 0;
        chk("simfull_empty", a_empty, 1);

        // simultaneous while empty: write wins, no bypass
        a_wr_en = 1; a_rd_en = 1; a_wr_data = 8'h55;
        step();
        a_wr_en = 0;
        chk("simempty_count", a_count, 1);
        chk("simempty_unf", a_unf, 1);
        chk("simempty_valid", a_rd_valid, 0);
        step();
        a_rd_en = 0;
        chk("simempty_data", a_rd_data, 8'h55);
        chk("simempty_valid2", a_rd_valid, 1);
        chk("simempty_count2", a_count, 0);
        a_clr = 1;
        step();
        a_clr = 0;

        // pointer wrap
        for (int i = 0; i < 5; i++) begin
            a_wr_en = 1; a_wr_data = 8'(8'h20 + i);
            step();
        end
        a_wr_en = 0;
        for (int i = 0; i < 5; i++) begin
            a_rd_en = 1;
            step();
            chk("wrap_pre", a_rd_data, 8'(8'h20 + i));
        end
        a_rd_en = 0;
        for (int i = 0; i < 3; i++) begin
            a_wr_en = 1; a_wr_data = 8'(8'h40 + i);
            step();
        end
        for (int j = 0; j < 20; j++) begin
            a_wr_en = 1; a_rd_en = 1; a_wr_data = 8'(8'h43 + j);
            step();
            chk("stream_data", a_rd_data, 8'(8'h40 + j));
            chk("stream_valid", a_rd_valid, 1);
            chk("stream_count", a_count, 3);
            chk("stream_status", {a_st(), a_ovf, a_unf}, 6'b000000);
        end
        a_wr_en = 0;
        for (int j = 20; j < 23; j++) begin
            step();
            chk("stream_tail", a_rd_data, 8'(8'h40 + j));
        end
        a_rd_en = 0;
        step();
        chk("stream_empty", a_empty, 1);

        // reset mid-stream at count 5
        for (int i = 0; i < 6; i++) begin
            a_wr_en = 1; a_wr_data = 8'(8'h60 + i);
            step();
        end
        a_wr_en = 0; a_rd_en = 1;
        step();
        a_rd_en = 0;
        chk("pre_rst_count", a_count, 5);
        chk("pre_rst_valid", a_rd_valid, 1);
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_count", a_count, 0);
        chk("mid_rst_empty", a_empty, 1);
        chk("mid_rst_valid", a_rd_valid, 0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_data", a_rd_data, 0);
        a_rd_en = 1;
        step();
        a_rd_en = 0;
        chk("post_rst_noread", a_rd_valid, 0);
        chk("post_rst_unf", a_unf, 1);
        a_wr_en = 1; a_wr_data = 8'h99;
        step();
        a_wr_en = 0; a_rd_en = 1;
        step();
        a_rd_en = 0;
        chk("post_rst_fresh", a_rd_data, 8'h99);

        // FWFT instance
        chk("fwft_rst", {b_empty, b_rd_valid}, 2'b10);
        b_wr_en = 1; b_wr_data = 8'hA5;
        step();
        b_wr_en = 0;
        chk("fwft_data", b_rd_data, 8'hA5);
        chk("fwft_valid", b_rd_valid, 1);
        step();
        chk("fwft_hold", {b_rd_valid, b_rd_data}, 9'h1A5);
        b_rd_en = 1;
        step();
        b_rd_en = 0;
        chk("fwft_pop_valid", b_rd_valid, 0);
        chk("fwft_pop_empty", b_empty, 1);
        b_wr_en = 1; b_wr_data = 8'h3C;
        step();
        b_wr_data = 8'hC3;
        step();
        b_wr_en = 0;
        chk("fwft_head1", b_rd_data, 8'h3C);
        b_rd_en = 1;
        step();
        chk("fwft_head2", b_rd_data, 8'hC3);
        step();
        b_rd_en = 0;
        chk("fwft_end", {b_empty, b_rd_valid, b_unf}, 3'b100);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO: the next generation of the team's 8-bit/64-entry synchronous FIFO, generalised in data width and depth. It adds programmable almost-full/almost-empty thresholds, a selectable first-word-fall-through (FWFT) read mode, a registered read-valid strobe and sticky overflow/underflow error flags. It sits between producer and consumer datapath stages in one clock domain.

## Interface
- DATA_W, default 8: data word width in bits, ≥1.
- DEPTH, default 64: number of entries; power of two, ≥4. AW = log2(DEPTH).
- AF_THRESH, default DEPTH-4: almost_full asserts when count ≥ AF_THRESH; range 1..DEPTH.
- AE_THRESH, default 4: almost_empty asserts when count ≤ AE_THRESH; range 0..DEPTH-1.
- FWFT, default 0: 0 = registered read, 1 = first-word-fall-through.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- wr_en  in  1  write request.
- wr_data  in  DATA_W  write data.
- rd_en  in  1  read request (FWFT=1: pop/acknowledge of the head word).
- rd_data  out  DATA_W  read data.
- rd_valid  out  1  rd_data holds a valid word (see Operation).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_THRESH.
- almost_empty  out  1  count ≤ AE_THRESH.
- count  out  AW+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.
- clr_err  in  1  synchronous clear of overflow and underflow.

## Operation
- Write accepted (wa) = wr_en & !full; read accepted (ra) = rd_en & !empty. Flags are decoded from the count register in the same cycle.
- On wa: mem[wr_ptr] ← wr_data and wr_ptr += 1. On ra: rd_ptr += 1. Pointers are AW bits wide and wrap DEPTH-1 → 0 modulo 2^AW, with no special case.
- count: +1 on wa only, −1 on ra only, unchanged on both or neither.
- Simultaneous wr_en and rd_en while full: the read is accepted, the write is rejected and overflow is set; count becomes DEPTH-1.
- Simultaneous wr_en and rd_en while empty: the write is accepted, the read is rejected and underflow is set; count becomes 1. There is no bypass of write data to the read port.
- FWFT=0: on ra, rd_data ← mem[rd_ptr] (registered) and rd_valid pulses 1 for the following cycle. Otherwise rd_data holds its value and rd_valid = 0.
- FWFT=1: rd_data = mem[rd_ptr] and rd_valid = !empty, both combinational from registers. rd_en pops the head word.
- overflow is set on wr_en & full; underflow is set on rd_en & empty. Both hold until clr_err. If a set event and clr_err occur in the same cycle, the set wins and the flag remains 1.
- Memory contents are not reset. Rejected writes leave memory unchanged.

## Timing
- Reset values: wr_ptr = rd_ptr = 0, count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0 (0 only when AF_THRESH > 0), rd_data = 0 (FWFT=0), rd_valid = 0, overflow = underflow = 0.
- An rst assertion mid-operation discards all stored words immediately. Memory contents are undefined to the user afterwards.
- Write-to-read latency into an empty FIFO: empty deasserts 1 cycle after the write edge.
  - FWFT=1: rd_data is valid in that same cycle.
  - FWFT=0: rd_en issued in that cycle produces rd_data and rd_valid on the next edge, i.e. 2 cycles from the write.
- Read latency FWFT=0: 1 cycle from ra to rd_data/rd_valid.
- Sustained throughput: 1 write and 1 read per cycle, at any occupancy from 1 to DEPTH-1.
- All status outputs update 1 cycle after the accepted event that changes count.

## Test plan
Configuration for all scenarios: DATA_W=8, DEPTH=8, AF_THRESH=6, AE_THRESH=2.
- Reset/fill/drain, FWFT=0:
  - After reset, check empty=1, count=0.
  - Write 0x01..0x08 on consecutive cycles → full=1, count=8, almost_full asserted from count 6.
  - Read 8 times → rd_data 0x01..0x08 each 1 cycle after rd_en with rd_valid=1, then empty=1.
- Overflow/underflow, FWFT=0:
  - A 9th write while full → data discarded, count stays 8, overflow=1.
  - Read while empty → underflow=1, rd_valid=0.
  - Pulse clr_err → both flags 0; with a simultaneous wr_en while full → overflow stays 1.
- Simultaneous at the boundaries:
  - At count=8, assert wr_en and rd_en → count=7, overflow=1.
  - At count=0, assert wr_en and rd_en → count=1, underflow=1, rd_valid=0.
- Pointer wrap:
  - Write 5 and read 5, then stream 20 words with wr_en=rd_en=1 every cycle.
  - Required: output order is exact, count is constant, and no flag toggles.
- FWFT=1:
  - Write 0xA5 into empty → the next cycle rd_data=0xA5 and rd_valid=1 without rd_en.
  - Pop with rd_en → rd_valid=0 and empty=1.
- Reset mid-stream:
  - At count=5, assert rst asynchronously mid-cycle → count=0, empty=1, rd_valid=0 immediately, and no stale data appears after release.
